// File: rtl/mem_write_checker.sv
// Store monitor for the MIPS data-memory write port: matches stores against a
// programmable in-order list of address/data pairs. Optional macro: MWCHK_TIMEOUT_EN.
module mem_write_checker #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int STRICT  = 0,
  parameter int TIMEOUT = 1000,
  localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_idx,
  input  logic [WIDTH-1:0] cfg_adr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [IW:0]      exp_count,
  input  logic             start,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] dataadr,
  input  logic [WIDTH-1:0] writedata,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [WIDTH-1:0] fail_adr,
  output logic [WIDTH-1:0] fail_data,
  output logic [IW:0]      match_idx
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_PASS  = 2'd2;
  localparam logic [1:0] S_FAIL  = 2'd3;

  localparam logic [1:0] CODE_NONE     = 2'd0;
  localparam logic [1:0] CODE_MISMATCH = 2'd1;
  localparam logic [1:0] CODE_TIMEOUT  = 2'd2;

  // Table is sized to the full index range so match_idx can never address past it.
  localparam int          NSLOT   = 1 << IW;
  localparam logic [IW:0] DEPTH_C = (IW+1)'(DEPTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] exp_adr_q  [NSLOT];
  logic [WIDTH-1:0] exp_data_q [NSLOT];
  logic [IW:0]      cnt_q, cnt_d;
  logic [IW:0]      match_q, match_d;
  logic [1:0]       code_q, code_d;
  logic [WIDTH-1:0] fadr_q, fadr_d;
  logic [WIDTH-1:0] fdata_q, fdata_d;
  logic             busy_q, pass_q, fail_q;

  logic             cfg_ok;
  logic [IW:0]      exp_sat;
  logic             in_unknown;
  logic             hit;
  logic             miss;
  logic [IW-1:0]    cur;

`ifdef MWCHK_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [TW-1:0] tmr_q, tmr_d;
  logic          tmo_hit;

  always_comb begin
    tmr_d = tmr_q;
    if (state_q == S_ARMED) begin
      tmr_d = tmr_q + 1'b1;
    end else if (start) begin
      tmr_d = '0;
    end
  end

  // Fires on the edge where the count of ARMED cycles reaches TIMEOUT.
  assign tmo_hit = (state_q == S_ARMED) && (tmr_d == TW'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end
`else
  logic tmo_hit;
  // Constant 0: no timeout in this build, TIMEOUT has no effect.
  assign tmo_hit = (TIMEOUT < 0);
`endif

  assign cfg_ok     = cfg_we && (state_q != S_ARMED) && (int'(cfg_idx) < DEPTH);
  assign exp_sat    = (exp_count > DEPTH_C) ? DEPTH_C : exp_count;
  assign in_unknown = $isunknown({memwrite, dataadr, writedata});
  assign cur        = match_q[IW-1:0];

  assign hit  = memwrite && !in_unknown &&
                (dataadr == exp_adr_q[cur]) && (writedata == exp_data_q[cur]);
  assign miss = memwrite && !hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    match_d = match_q;
    code_d  = code_q;
    fadr_d  = fadr_q;
    fdata_d = fdata_q;

    case (state_q)
      S_ARMED: begin
        if (hit) begin
          match_d = match_q + 1'b1;
          if (match_d == cnt_q) begin
            state_d = S_PASS;
          end
        end else if (miss && (STRICT != 0)) begin
          state_d = S_FAIL;
          code_d  = CODE_MISMATCH;
          fadr_d  = dataadr;
          fdata_d = writedata;
        end
        // A final match on the timeout edge has already left ARMED and wins.
        if ((state_d == S_ARMED) && tmo_hit) begin
          state_d = S_FAIL;
          code_d  = CODE_TIMEOUT;
          fadr_d  = '0;
          fdata_d = '0;
        end
      end
      default: begin
        if (start) begin
          cnt_d   = exp_sat;
          match_d = '0;
          code_d  = CODE_NONE;
          fadr_d  = '0;
          fdata_d = '0;
          state_d = (exp_sat == '0) ? S_PASS : S_ARMED;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      match_q <= '0;
      code_q  <= CODE_NONE;
      fadr_q  <= '0;
      fdata_q <= '0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      code_q  <= code_d;
      fadr_q  <= fadr_d;
      fdata_q <= fdata_d;
      busy_q  <= (state_d == S_ARMED);
      pass_q  <= (state_d == S_PASS);
      fail_q  <= (state_d == S_FAIL);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        exp_adr_q[i]  <= '0;
        exp_data_q[i] <= '0;
      end
    end else if (cfg_ok) begin
      exp_adr_q[cfg_idx]  <= cfg_adr;
      exp_data_q[cfg_idx] <= cfg_data;
    end
  end

  assign busy      = busy_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_code = code_q;
  assign fail_adr  = fadr_q;
  assign fail_data = fdata_q;
  assign match_idx = match_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: a lenient (STRICT=0) and a strict
// (STRICT=1) instance share one stimulus stream; timeout checks need MWCHK_TIMEOUT_EN.
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_adr, cfg_data;
  logic [2:0]  exp_count;
  logic        start, memwrite;
  logic [31:0] dataadr, writedata;

  logic        l_busy, l_pass, l_fail, s_busy, s_pass, s_fail;
  logic [1:0]  l_code, s_code;
  logic [31:0] l_fa, l_fd, s_fa, s_fd;
  logic [2:0]  l_m, s_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_write_checker #(.WIDTH(32), .DEPTH(4), .STRICT(0), .TIMEOUT(20)) u_lax (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr),
    .cfg_data(cfg_data), .exp_count(exp_count), .start(start), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .busy(l_busy), .pass(l_pass),
    .fail(l_fail), .fail_code(l_code), .fail_adr(l_fa), .fail_data(l_fd),
    .match_idx(l_m));

  mem_write_checker #(.WIDTH(32), .DEPTH(4), .STRICT(1), .TIMEOUT(20)) u_strict (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr),
    .cfg_data(cfg_data), .exp_count(exp_count), .start(start), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .busy(s_busy), .pass(s_pass),
    .fail(s_fail), .fail_code(s_code), .fail_adr(s_fa), .fail_data(s_fd),
    .match_idx(s_m));

  typedef struct {
    logic        cwe;
    logic [1:0]  cidx;
    logic [31:0] cadr, cdat;
    logic [2:0]  ecnt;
    logic        st, mw;
    logic [31:0] adr, dat;
    logic [2:0]  l_bpf;   // lenient {busy,pass,fail}
    logic [2:0]  l_m;
    logic [2:0]  s_bpf;   // strict {busy,pass,fail}
    logic [1:0]  s_code;
    logic [2:0]  s_m;
    logic [31:0] s_fa, s_fd;
  } vec_t;

  vec_t tbl [24];

  function automatic logic [71:0] pack_l();
    return {l_busy, l_pass, l_fail, l_code, l_m, l_fa, l_fd};
  endfunction

  function automatic logic [71:0] pack_s();
    return {s_busy, s_pass, s_fail, s_code, s_m, s_fa, s_fd};
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic cwe, input logic [1:0] cidx, input logic [31:0] cadr,
                       input logic [31:0] cdat, input logic [2:0] ecnt, input logic st,
                       input logic mw, input logic [31:0] adr, input logic [31:0] dat);
    cfg_we = cwe; cfg_idx = cidx; cfg_adr = cadr; cfg_data = cdat;
    exp_count = ecnt; start = st; memwrite = mw; dataadr = adr; writedata = dat;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            cwe  idx  cadr    cdat    ecnt st   mw   adr     dat     l_bpf   l_m   s_bpf   code  s_m   s_fa    s_fd
    tbl[0]  = '{1'b1,2'd0,32'd84, 32'd5,  3'd0,1'b0,1'b0,32'd0,  32'd0,  3'b000,3'd0,3'b000,2'd0,3'd0,32'd0,  32'd0};
    tbl[1]  = '{1'b0,2'd0,32'd0,  32'd0,  3'd1,1'b1,1'b0,32'd0,  32'd0,  3'b100,3'd0,3'b100,2'd0,3'd0,32'd0,  32'd0};
    tbl[2]  = '{1'b0,2'd0,32'd0,  32'd0,  3'd0,1'b0,1'b1,32'd84, 32'd5,  3'b010,3'd1,3'b010,2'd0,3'd1,32'd0,  32'd0};
    tbl[3]  = '{1'b0,2'd0,32'd0,  32'd0,  3'd0,1'b0,1'b0,32'd0,  32'd0,  3'b010,3'd1,3'b010,2'd0,3'd1,32'd0,  32'd0};
    tbl[4]  = '{1'b1,2'd0,32'd0,  32'd7,  3'd0,1'b0,1'b0,32'd0,  32'd0,  3'b010,3'd1,3'b010,2'd0,3'd1,32'd0,  32'd0};
    tbl[5]  = '{1'b1,2'd1,32'd4,  32'd9,  3'd0,1'b0,1'b0,32'd0,  32'd0,  3'b010,3'd1,3'b010,2'd0,3'd1,32'd0,  32'd0};
    tbl[6]  = '{1'b0,2'd0,32'd0,  32'd0,  3'd2,1'b1,1'b0,32'd0,  32'd0,  3'b100,3'd0,3'b100,2'd0,3'd0,32'd0,  32'd0};
    tbl[7]  = '{1'b0,2'd0,32'd0,  32'd0,  3'd0,1'b0,1'b1,32'd0,  32'd7,  3'b100,3'd1,3'b100,2'd0,3'd1,32'd0,  32'd0};
    tbl[8]  = '{1'b0,2'd0,32'd0,  32'd0,  3'd0,1'b0,1'b1,32'd4,  32'd8,  3'b100,3'd1,3'b001,2'd1,3'd1,32'd4,  32'd8};
    tbl[9]  = '{1'b0,2'd0,32'd0,  32'd0,  3'd0,1'b0,1'b1,32'd8,  32'd1,  3'b100,3'd1,3'b001,2'd1,3'd1,32'd4,  32'd8};
    tbl[10] = '{1'b0,2'd0,32'd0,  32'd0,  3'd0,1'b0,1'b1,32'd4,  32'd9,  3'b010,3'd2,3'b001,2'd1,3'd1,32'd4,  32'd8};
    tbl[11] = '{1'b0,2'd0,32'd0,  32'd0,  3'd0,1'b1,1'b0,32'd0,  32'd0,  3'b010,3'd0,3'b010,2'd0,3'd0,32'd0,  32'd0};
    tbl[12] = '{1'b0,2'd0,32'd0,  32'd0,  3'd2,1'b1,1'b1,32'd9,  32'd9,  3'b100,3'd0,3'b100,2'd0,3'd0,32'd0,  32'd0};
    tbl[13] = '{1'b0,2'd0,32'd0,  32'd0,  3'd0,1'b0,1'b1,32'd0,  32'd7,  3'b100,3'd1,3'b100,2'd0,3'd1,32'd0,  32'd0};
    tbl[14] = '{1'b0,2'd0,32'd0,  32'd0,  3'd1,1'b1,1'b1,32'd4,  32'd9,  3'b010,3'd2,3'b010,2'd0,3'd2,32'd0,  32'd0};
    tbl[15] = '{1'b0,2'd0,32'd0,  32'd0,  3'd7,1'b1,1'b0,32'd0,  32'd0,  3'b100,3'd0,3'b100,2'd0,3'd0,32'd0,  32'd0};
    tbl[16] = '{1'b1,2'd0,32'd100,32'd100,3'd0,1'b0,1'b0,32'd0,  32'd0,  3'b100,3'd0,3'b100,2'd0,3'd0,32'd0,  32'd0};
    tbl[17] = '{1'b0,2'd0,32'd0,  32'd0,  3'd0,1'b0,1'b1,32'd0,  32'd7,  3'b100,3'd1,3'b100,2'd0,3'd1,32'd0,  32'd0};
    tbl[18] = '{1'b0,2'd0,32'd0,  32'd0,  3'd0,1'b0,1'b1,32'd4,  32'd9,  3'b100,3'd2,3'b100,2'd0,3'd2,32'd0,  32'd0};
    tbl[19] = '{1'b0,2'd0,32'd0,  32'd0,  3'd0,1'b0,1'b1,32'd0,  32'd0,  3'b100,3'd3,3'b100,2'd0,3'd3,32'd0,  32'd0};
    tbl[20] = '{1'b0,2'd0,32'd0,  32'd0,  3'd0,1'b0,1'b1,32'd0,  32'd0,  3'b010,3'd4,3'b010,2'd0,3'd4,32'd0,  32'd0};
    tbl[21] = '{1'b0,2'd0,32'd0,  32'd0,  3'd1,1'b1,1'b0,32'd0,  32'd0,  3'b100,3'd0,3'b100,2'd0,3'd0,32'd0,  32'd0};
    tbl[22] = '{1'b0,2'd0,32'd0,  32'd0,  3'd0,1'b0,1'b1,32'd100,32'd100,3'b100,3'd0,3'b001,2'd1,3'd0,32'd100,32'd100};
    tbl[23] = '{1'b0,2'd0,32'd0,  32'd0,  3'd0,1'b0,1'b1,32'd0,  32'd7,  3'b010,3'd1,3'b001,2'd1,3'd0,32'd100,32'd100};

    reset = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_adr = '0; cfg_data = '0;
    exp_count = '0; start = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_lax", pack_l(), 72'd0);
    chk("reset_strict", pack_s(), 72'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].cwe, tbl[i].cidx, tbl[i].cadr, tbl[i].cdat, tbl[i].ecnt,
            tbl[i].st, tbl[i].mw, tbl[i].adr, tbl[i].dat);
      chk($sformatf("vec%0d_lax", i), pack_l(), {tbl[i].l_bpf, 2'd0, tbl[i].l_m, 64'd0});
      chk($sformatf("vec%0d_strict", i), pack_s(),
          {tbl[i].s_bpf, tbl[i].s_code, tbl[i].s_m, tbl[i].s_fa, tbl[i].s_fd});
    end

    // Asynchronous reset mid-run with one entry already matched.
    drive(1'b0, 2'd0, 32'd0, 32'd0, 3'd2, 1'b1, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b1, 32'd0, 32'd7);
    chk("pre_reset_lax", pack_l(), {3'b100, 2'd0, 3'd1, 64'd0});
    chk("pre_reset_strict", pack_s(), {3'b100, 2'd0, 3'd1, 64'd0});
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset_lax", pack_l(), 72'd0);
    chk("async_reset_strict", pack_s(), 72'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 2'd0, 32'd84, 32'd5, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("post_reset_cfg", pack_s(), 72'd0);
    drive(1'b0, 2'd0, 32'd0, 32'd0, 3'd1, 1'b1, 1'b0, 32'd0, 32'd0);
    chk("post_reset_arm", pack_s(), {3'b100, 2'd0, 3'd0, 64'd0});
    drive(1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b1, 32'd84, 32'd5);
    chk("post_reset_pass_lax", pack_l(), {3'b010, 2'd0, 3'd1, 64'd0});
    chk("post_reset_pass_strict", pack_s(), {3'b010, 2'd0, 3'd1, 64'd0});

    // Timeout: busy rises on the start edge, fail exactly 20 edges later.
    drive(1'b0, 2'd0, 32'd0, 32'd0, 3'd1, 1'b1, 1'b0, 32'd0, 32'd0);
    chk("tmo_arm", pack_s(), {3'b100, 2'd0, 3'd0, 64'd0});
`ifdef MWCHK_TIMEOUT_EN
    for (int k = 1; k < 20; k++) begin
      drive(1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      chk($sformatf("tmo_wait%0d", k), {69'd0, s_busy, s_pass, s_fail}, {69'd0, 3'b100});
    end
    drive(1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("tmo_fire_strict", pack_s(), {3'b001, 2'd2, 3'd0, 64'd0});
    chk("tmo_fire_lax", pack_l(), {3'b001, 2'd2, 3'd0, 64'd0});
`else
    for (int k = 1; k <= 40; k++) begin
      drive(1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    chk("no_tmo_strict", pack_s(), {3'b100, 2'd0, 3'd0, 64'd0});
    chk("no_tmo_lax", pack_l(), {3'b100, 2'd0, 3'd0, 64'd0});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesisable, self-checking store monitor for the MIPS core's data-memory write port. It watches `memwrite`/`dataadr`/`writedata` and matches stores against a programmable list of up to DEPTH expected address/data pairs, in order. It reports pass, mismatch or timeout with registered status flags. It sits beside `top` in simulation and FPGA bring-up, replacing the single hard-coded "address 84 = 5" end-of-test check.

## Interface
- `WIDTH`, 32: address/data width.
- `DEPTH`, 4: maximum number of expected stores; IW = $clog2(DEPTH), minimum 1.
- `STRICT`, 0: 1 = any non-matching store while armed is a failure; 0 = non-matching stores are ignored.
- `TIMEOUT`, 1000: cycles allowed from arm to final match; TW = $clog2(TIMEOUT+1).

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `cfg_we`  in  1  write one expected-store entry
- `cfg_idx`  in  IW  entry index
- `cfg_adr`  in  WIDTH  expected address
- `cfg_data`  in  WIDTH  expected data
- `exp_count`  in  IW+1  number of entries to check; sampled on `start`
- `start`  in  1  arm the checker (one-cycle pulse)
- `memwrite`  in  1  store strobe from core
- `dataadr`  in  WIDTH  store address
- `writedata`  in  WIDTH  store data
- `busy`  out  1  armed and checking
- `pass`  out  1  all expected stores seen (sticky)
- `fail`  out  1  failure detected (sticky)
- `fail_code`  out  2  0 none, 1 mismatch, 2 timeout
- `fail_adr`  out  WIDTH  address of offending store (0 on timeout)
- `fail_data`  out  WIDTH  data of offending store (0 on timeout)
- `match_idx`  out  IW+1  number of entries matched so far

## Operation
- States: IDLE, ARMED, PASS, FAIL. Reset (`reset`=0) → IDLE. All outputs are 0. Expected table, counters and `exp_count` latch are cleared.
- `cfg_we` writes entry `cfg_idx` in IDLE, PASS or FAIL. `cfg_we` is ignored in ARMED. `cfg_idx` ≥ DEPTH is ignored.
- `start` in IDLE/PASS/FAIL:
  - latches `exp_count`, saturated to DEPTH;
  - clears `match_idx`, the cycle counter, flags and fail capture;
  - enters ARMED.
  - If the latched count is 0, the block goes directly to PASS instead.
  - `start` in ARMED is ignored.
- ARMED, each cycle with `memwrite`=1:
  - If `dataadr`/`writedata` equal entry[`match_idx`], `match_idx` increments. When it reaches the latched count → PASS.
  - Else if STRICT=1 → FAIL, code 1, with `fail_adr`/`fail_data` capturing the store.
  - Else (STRICT=0) the store is ignored.
- Any X/Z bit on `memwrite`, `dataadr` or `writedata` in ARMED is treated as a non-match.
- Timeout: the cycle counter increments every ARMED cycle. When it reaches TIMEOUT with no PASS → FAIL, code 2.
- PASS and FAIL are held until `start` or reset. `busy` = (state == ARMED).

## Timing
- Inputs are sampled on the rising edge of `clk`. All outputs are registered.
- `pass`/`fail` assert one cycle after the deciding store is sampled.
- `busy` rises the cycle after `start` and falls in the same cycle that `pass`/`fail` rise.
- `start` and `memwrite` in the same cycle in IDLE: the store is not checked. The first checked store is in the following cycle.
- A final match and the timeout in the same cycle: match wins, and the result is PASS.
- Back-to-back stores on consecutive cycles are checked without gaps. `match_idx` advances by at most 1 per cycle.
- Asserting `reset` mid-run returns the block to IDLE immediately (asynchronously) and clears all outputs.

## Configuration
- `MWCHK_TIMEOUT_EN`:
  - Defined: the cycle counter and the timeout behaviour above are compiled in.
  - Undefined: there is no counter, ARMED can last indefinitely, fail_code 2 is unreachable, and the `TIMEOUT` parameter is unused.

## Test plan
- Program entry0 = (84, 5), `exp_count`=1, `start`, then store 84/5 → `pass`=1 one cycle later, `match_idx`=1, `busy`=0.
- STRICT=1, entries (0,7),(4,9), stores 0/7 then 4/8 → `fail`=1, `fail_code`=1, `fail_adr`=4, `fail_data`=8, `match_idx`=1.
- STRICT=0, same entries, stores 0/7, 8/1, 4/9 → `pass`=1; the 8/1 store is ignored.
- With `MWCHK_TIMEOUT_EN` defined, TIMEOUT=20, `exp_count`=1, no stores → `fail` rises 20 cycles after `busy` rises, `fail_code`=2.
- `start` with `exp_count`=0 → `pass`=1 the next cycle, `busy` never asserts.
- Reset (`reset`=0) asserted while ARMED with `match_idx`=1 → all outputs 0 immediately. After release, `cfg_we` is accepted and a re-armed run passes.
